// File: rtl/fpu_pkg.sv
// Shared types and helpers for the sequential IEEE-754 multiplier.
package fpu_pkg;

  typedef enum logic [2:0] {IDLE, UNPK, MUL, RND, DONE} fsm_state_t;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

  localparam int unsigned MAX_W = 128;

  function automatic int unsigned exp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [MAX_W-1:0] qnan_word(input int unsigned exp_w,
                                                 input int unsigned man_w);
    logic [MAX_W-1:0] w;
    w = (((MAX_W'(1) << exp_w) - MAX_W'(1)) << man_w) | (MAX_W'(1) << (man_w - 1));
    return w;
  endfunction

endpackage

// File: rtl/fpu_mult_seq_mant_mul.sv
// Radix-2 shift-add significand multiplier; one partial product per cycle.
module fp_mant_iter_mul
  import fpu_pkg::*;
#(
  parameter int N = 53
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] prod
);

  localparam int CNT_W = $clog2(N);

  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [CNT_W-1:0] cnt;
  logic           busy;

  // Terminal count: the final partial product is added on this edge.
  assign done = busy && (cnt == CNT_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{N{1'b0}}, a};
      mplier <= b;
      prod   <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) busy <= 1'b0;
      else      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fpu_mult_seq.sv
// Sequential IEEE-754 multiplier: valid/ready handshake, iterative significand
// multiply, round-to-nearest-even, flush-to-zero in and out.
module fpu_mult_seq
  import fpu_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52,
  parameter int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         overflow_flag,
  output logic         underflow_flag,
  output logic         invalid_flag,
  output logic         inexact_flag
);

  localparam int N  = MAN_W + 1;
  localparam int EW = EXP_W + 2;

  localparam logic [W-1:0]         QNAN   = W'(qnan_word(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] BIAS_S = EW'(exp_bias(EXP_W));
  localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE_S  = EW'(1);

  function automatic fp_class_t classify(input logic [EXP_W-1:0] e,
                                         input logic [MAN_W-1:0] f);
    if (e == '0) return ZERO;
    if (e == '1) return (f == '0) ? INF : NAN;
    return NORM;
  endfunction

  fsm_state_t state;

  logic [W-1:0]         x_r, y_r;
  logic                 sign_r;
  logic signed [EW-1:0] e_base;
  logic                 special_r;
  logic [W-1:0]         spec_res;
  logic                 spec_inv;

  // Operand unpack
  logic [EXP_W-1:0]     ex, ey;
  logic [MAN_W-1:0]     fx, fy;
  logic                 sign_c;
  fp_class_t            cx, cy;
  logic signed [EW-1:0] ex_s, ey_s, e_sum_c;

  assign ex     = x_r[W-2 -: EXP_W];
  assign ey     = y_r[W-2 -: EXP_W];
  assign fx     = x_r[MAN_W-1:0];
  assign fy     = y_r[MAN_W-1:0];
  assign sign_c = x_r[W-1] ^ y_r[W-1];
  assign cx     = classify(ex, fx);
  assign cy     = classify(ey, fy);
  assign ex_s   = $signed({2'b00, ex});
  assign ey_s   = $signed({2'b00, ey});
  assign e_sum_c = ex_s + ey_s - BIAS_S;

  logic         special_c;
  logic         spec_inv_c;
  logic [W-1:0] spec_res_c;

  always_comb begin
    special_c  = 1'b1;
    spec_inv_c = 1'b0;
    spec_res_c = '0;
    if (cx == NAN || cy == NAN || (cx == INF && cy == ZERO) || (cx == ZERO && cy == INF)) begin
      spec_res_c = QNAN;
      spec_inv_c = 1'b1;
    end else if (cx == INF || cy == INF) begin
      spec_res_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cx == ZERO || cy == ZERO) begin
      spec_res_c = {sign_c, {(W-1){1'b0}}};
    end else begin
      special_c = 1'b0;
    end
  end

  // Significand multiplier
  logic           mul_start, mul_done;
  logic [2*N-1:0] prod;

  assign mul_start = (state == UNPK) && !special_c;

  fp_mant_iter_mul #(.N(N)) u_mant_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     ({|ex, fx}),
    .b     ({|ey, fy}),
    .done  (mul_done),
    .prod  (prod)
  );

  // Normalise and round. Left-aligning the unnormalised case lets both cases
  // share one fixed set of guard/round/sticky positions.
  logic                 norm;
  logic [2*N-1:0]       pn;
  logic [N-1:0]         mant;
  logic                 g_bit, r_bit, s_bit, rup;
  logic [N:0]           mant_r;
  logic                 carry;
  logic [MAN_W-1:0]     frac;
  logic signed [EW-1:0] inc_s, e_fin;
  logic                 ovf, unf;

  assign norm   = prod[2*N-1];
  assign pn     = norm ? prod : (prod << 1);
  assign mant   = pn[2*N-1 -: N];
  assign g_bit  = pn[MAN_W];
  assign r_bit  = pn[MAN_W-1];
  assign s_bit  = |pn[MAN_W-2:0];
  assign rup    = g_bit & (r_bit | s_bit | mant[0]);
  assign mant_r = {1'b0, mant} + {{N{1'b0}}, rup};
  assign carry  = mant_r[N];
  assign frac   = carry ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
  assign inc_s  = {{(EW-2){1'b0}}, norm & carry, norm ^ carry};
  assign e_fin  = e_base + inc_s;
  assign ovf    = (e_fin >= EMAX_S);
  assign unf    = (e_fin < ONE_S);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      res            <= '0;
      overflow_flag  <= 1'b0;
      underflow_flag <= 1'b0;
      invalid_flag   <= 1'b0;
      inexact_flag   <= 1'b0;
      x_r            <= '0;
      y_r            <= '0;
      sign_r         <= 1'b0;
      e_base         <= '0;
      special_r      <= 1'b0;
      spec_res       <= '0;
      spec_inv       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            x_r            <= X;
            y_r            <= Y;
            in_ready       <= 1'b0;
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
            invalid_flag   <= 1'b0;
            inexact_flag   <= 1'b0;
            state          <= UNPK;
          end
        end
        UNPK: begin
          sign_r    <= sign_c;
          e_base    <= e_sum_c;
          special_r <= special_c;
          spec_res  <= spec_res_c;
          spec_inv  <= spec_inv_c;
          state     <= special_c ? RND : MUL;
        end
        MUL: begin
          if (mul_done) state <= RND;
        end
        RND: begin
          if (special_r) begin
            res          <= spec_res;
            invalid_flag <= spec_inv;
          end else if (ovf) begin
            res           <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            overflow_flag <= 1'b1;
            inexact_flag  <= 1'b1;
          end else if (unf) begin
            // Flushed result is inexact only when rounding discarded bits.
            res            <= {sign_r, {(W-1){1'b0}}};
            underflow_flag <= 1'b1;
            inexact_flag   <= g_bit | r_bit | s_bit;
          end else begin
            res          <= {sign_r, e_fin[EXP_W-1:0], frac};
            inexact_flag <= g_bit | r_bit | s_bit;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mult_seq.sv
// Scoreboard bench for fpu_mult_seq in binary64 and binary32 configurations.
module tb_fpu_mult_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  logic        in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b1;
  logic [63:0] x_a = '0, y_a = '0, res_a;
  logic        ovf_a, unf_a, inv_a, inx_a;

  logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1;
  logic [31:0] x_b = '0, y_b = '0, res_b;
  logic        ovf_b, unf_b, inv_b, inx_b;

  fpu_mult_seq dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .X(x_a), .Y(y_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .res(res_a),
    .overflow_flag(ovf_a), .underflow_flag(unf_a), .invalid_flag(inv_a), .inexact_flag(inx_a)
  );

  fpu_mult_seq #(.EXP_W(8), .MAN_W(23)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .X(x_b), .Y(y_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .res(res_b),
    .overflow_flag(ovf_b), .underflow_flag(unf_b), .invalid_flag(inv_b), .inexact_flag(inx_b)
  );

  typedef struct { logic [63:0] res; logic [3:0] flg; int lat; int acc; } exp_t;
  typedef struct { logic [63:0] x; logic [63:0] y; logic [63:0] r; logic [3:0] f; int lat; } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop on the first cycle of out_valid, then require a stable hold.
  logic held_a = 1'b0, held_b = 1'b0;
  exp_t cur_a, cur_b;

  always @(negedge clk) begin
    if (!rst_n) held_a = 1'b0;
    else if (out_valid_a) begin
      if (!held_a) begin
        held_a = 1'b1;
        if (q_a.size() == 0) check("spurious_out_a", 64'(out_valid_a), 64'd0);
        else begin
          cur_a = q_a.pop_front();
          check("res_a", res_a, cur_a.res);
          check("flags_a", 64'({ovf_a, unf_a, inv_a, inx_a}), 64'(cur_a.flg));
          check("latency_a", 64'(edge_n - cur_a.acc + 1), 64'(cur_a.lat));
        end
      end else begin
        check("hold_res_a", res_a, cur_a.res);
        check("hold_flags_a", 64'({ovf_a, unf_a, inv_a, inx_a}), 64'(cur_a.flg));
        check("hold_in_ready_a", 64'(in_ready_a), 64'd0);
      end
      if (out_ready_a) held_a = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) held_b = 1'b0;
    else if (out_valid_b) begin
      if (!held_b) begin
        held_b = 1'b1;
        if (q_b.size() == 0) check("spurious_out_b", 64'(out_valid_b), 64'd0);
        else begin
          cur_b = q_b.pop_front();
          check("res_b", 64'(res_b), cur_b.res);
          check("flags_b", 64'({ovf_b, unf_b, inv_b, inx_b}), 64'(cur_b.flg));
          check("latency_b", 64'(edge_n - cur_b.acc + 1), 64'(cur_b.lat));
        end
      end
      if (out_ready_b) held_b = 1'b0;
    end
  end

  task automatic issue_a(input vec_t v, input bit expect_out);
    int guard = 0;
    exp_t e;
    while (!in_ready_a && guard < 300) begin tick(); guard++; end
    if (!in_ready_a) check("accept_timeout_a", 64'(in_ready_a), 64'd1);
    x_a = v.x; y_a = v.y; in_valid_a = 1'b1;
    e.res = v.r; e.flg = v.f; e.lat = v.lat; e.acc = edge_n + 1;
    if (expect_out) q_a.push_back(e);
    tick();
    in_valid_a = 1'b0;
  endtask

  task automatic issue_b(input vec_t v);
    int guard = 0;
    exp_t e;
    while (!in_ready_b && guard < 300) begin tick(); guard++; end
    if (!in_ready_b) check("accept_timeout_b", 64'(in_ready_b), 64'd1);
    x_b = v.x[31:0]; y_b = v.y[31:0]; in_valid_b = 1'b1;
    e.res = v.r; e.flg = v.f; e.lat = v.lat; e.acc = edge_n + 1;
    q_b.push_back(e);
    tick();
    in_valid_b = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || !in_ready_a || !in_ready_b) && guard < 300) begin
      tick();
      guard++;
    end
    if (guard >= 300) check("drain_timeout", 64'(q_a.size() + q_b.size()), 64'd0);
  endtask

  vec_t va[13];
  vec_t vb[4];

  initial begin
    // flags packed as {overflow, underflow, invalid, inexact}
    va[0]  = '{64'h4061D00000000000, 64'h4029000000000000, 64'h409BD50000000000, 4'b0000, 56};
    va[1]  = '{64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 64'h7FF0000000000000, 4'b1001, 56};
    va[2]  = '{64'h0010000000000000, 64'h3FE0000000000000, 64'h0000000000000000, 4'b0100, 56};
    va[3]  = '{64'h7FF0000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 4'b0010, 3};
    va[4]  = '{64'h3FF0000000000000, 64'hFFF0000000000001, 64'h7FF8000000000000, 4'b0010, 3};
    va[5]  = '{64'hFFF0000000000000, 64'h4000000000000000, 64'hFFF0000000000000, 4'b0000, 3};
    va[6]  = '{64'h8000000000000000, 64'h4008000000000000, 64'h8000000000000000, 4'b0000, 3};
    va[7]  = '{64'h0000000000000001, 64'h3FF0000000000000, 64'h0000000000000000, 4'b0000, 3};
    va[8]  = '{64'h3FF0000000000001, 64'h3FF0000000000001, 64'h3FF0000000000002, 4'b0001, 56};
    va[9]  = '{64'h3FF0000000000001, 64'h3FF8000000000000, 64'h3FF8000000000002, 4'b0001, 56};
    va[10] = '{64'h3FF0000000000003, 64'h3FF8000000000000, 64'h3FF8000000000004, 4'b0001, 56};
    va[11] = '{64'hBFF8000000000000, 64'h3FF8000000000000, 64'hC002000000000000, 4'b0000, 56};
    va[12] = '{64'h8010000000000000, 64'h3FE0000000000000, 64'h8000000000000000, 4'b0100, 56};

    vb[0] = '{64'h3FC00000, 64'h3FC00000, 64'h40100000, 4'b0000, 27};
    vb[1] = '{64'h7F7FFFFF, 64'h40000000, 64'h7F800000, 4'b1001, 27};
    vb[2] = '{64'h7FC00000, 64'h3F800000, 64'h7FC00000, 4'b0010, 3};
    vb[3] = '{64'h3F800001, 64'h3F800001, 64'h3F800002, 4'b0001, 27};

    repeat (2) tick();
    check("rst_in_ready_a", 64'(in_ready_a), 64'd1);
    check("rst_out_valid_a", 64'(out_valid_a), 64'd0);
    check("rst_res_a", res_a, 64'd0);
    check("rst_flags_a", 64'({ovf_a, unf_a, inv_a, inx_a}), 64'd0);
    check("rst_in_ready_b", 64'(in_ready_b), 64'd1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) issue_a(va[i], 1'b1);
    wait_idle();
    for (int i = 0; i < 4; i++) issue_b(vb[i]);
    wait_idle();

    // Backpressure: result must hold and fresh operands must be refused.
    out_ready_a = 1'b0;
    issue_a(va[1], 1'b1);
    for (int g = 0; g < 100 && !out_valid_a; g++) tick();
    repeat (10) begin
      in_valid_a = 1'b1;
      x_a = 64'h4000000000000000;
      y_a = 64'h4000000000000000;
      tick();
    end
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    wait_idle();
    issue_a(va[0], 1'b1);
    wait_idle();

    // Reset while the significand multiplier is iterating.
    issue_a(va[11], 1'b0);
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid_a", 64'(out_valid_a), 64'd0);
    check("midrst_in_ready_a", 64'(in_ready_a), 64'd1);
    check("midrst_res_a", res_a, 64'd0);
    check("midrst_flags_a", 64'({ovf_a, unf_a, inv_a, inx_a}), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (80) tick();
    check("postrst_in_ready_a", 64'(in_ready_a), 64'd1);
    check("postrst_out_valid_a", 64'(out_valid_a), 64'd0);
    issue_a(va[9], 1'b1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
